// File: rtl/mem_access_stage.sv
// MEM stage: takes one EX/MEM op per handshake, runs at most one data-memory
// transaction (req/gnt/rvalid) and hands the formatted result to MEM/WB.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int unsigned TimeoutCycles    = 256,
  parameter bit          ClearDataOnReset = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pipeline_flush,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  rd_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_data_o,
  output logic [31:0] mem_address_o,
  output logic [3:0]  rd_o,
  output logic        RegWrite_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [3:0]  rd;
    logic        regwrite;
    logic [2:0]  funct3;
    logic        we;
  } data_t;

  state_e          state_q, state_d;
  data_t           data_q, data_d;
  logic [3:0]      be_q, be_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            kill_q, kill_d;
  logic            misalign_q, misalign_d;

  logic        accept, killed, timeout_hit, mem_op, misaligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  // funct3[1:0]: 00 byte, 01 half, anything else treated as word; funct3[2] = unsigned.
  function automatic logic [31:0] fmt_load(logic [31:0] w, logic [1:0] a, logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   return {{24{b[7] & ~f3[2]}}, b};
      2'b01:   return {{16{h[15] & ~f3[2]}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    mem_op        = MemRead_i | MemWrite_i;
    misaligned_in = mem_op & (((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                              (funct3_i[1] & (|alu_result_i[1:0])));
    case (funct3_i[1:0])
      2'b00: begin
        be_in    = 4'b0001 << alu_result_i[1:0];
        wdata_in = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << alu_result_i[1:0];
        wdata_in = {2{store_data_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data_i;
      end
    endcase
  end

  assign ready_o = ~reset_i & ((state_q == StIdle) | ((state_q == StDone) & ready_i));
  // A flush in IDLE/DONE swallows any op offered in the same cycle.
  assign accept  = valid_i & ready_o & ~pipeline_flush;
  assign killed  = kill_q | pipeline_flush;
  // A grant (or read data) arriving in the expiry cycle takes priority over the abort.
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntMax) &&
                       (((state_q == StReq) && !dmem_gnt_i) ||
                        ((state_q == StWait) && !dmem_rvalid_i));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    misalign_d = 1'b0;

    case (state_q)
      StReq: begin
        cnt_d  = cnt_q + 1'b1;
        kill_d = killed;
        if (dmem_gnt_i) begin
          if (data_q.we) begin
            state_d = killed ? StIdle : StDone;
            kill_d  = 1'b0;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          data_d.regwrite = 1'b0;
          state_d         = killed ? StIdle : StDone;
          kill_d          = 1'b0;
        end
      end
      StWait: begin
        cnt_d  = cnt_q + 1'b1;
        kill_d = killed;
        if (dmem_rvalid_i) begin
          data_d.mdata = fmt_load(dmem_rdata_i, data_q.addr[1:0], data_q.funct3);
          state_d      = killed ? StIdle : StDone;
          kill_d       = 1'b0;
        end else if (timeout_hit) begin
          data_d.regwrite = 1'b0;
          state_d         = killed ? StIdle : StDone;
          kill_d          = 1'b0;
        end
      end
      StDone: begin
        if (pipeline_flush || (ready_i && !valid_i)) state_d = StIdle;
      end
      default: ;
    endcase

    if (accept) begin
      data_d.addr     = alu_result_i;
      data_d.wdata    = wdata_in;
      data_d.mdata    = MemWrite_i ? store_data_i : alu_result_i;
      data_d.rd       = rd_i;
      data_d.regwrite = RegWrite_i & ~MemWrite_i & ~misaligned_in;
      data_d.funct3   = funct3_i;
      data_d.we       = MemWrite_i;
      be_d            = be_in;
      cnt_d           = '0;
      kill_d          = 1'b0;
      if (!mem_op) begin
        state_d = StDone;
      end else if (misaligned_in) begin
        state_d    = StDone;
        misalign_d = 1'b1;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      be_q       <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  if (ClearDataOnReset) begin : g_data_clr
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) data_q <= '0;
      else         data_q <= data_d;
    end
  end else begin : g_data_keep
    always_ff @(posedge clk_i) begin
      data_q <= data_d;
    end
  end

  assign dmem_req_o    = (state_q == StReq);
  assign dmem_we_o     = dmem_req_o & data_q.we;
  assign dmem_be_o     = dmem_req_o ? be_q : 4'b0000;
  assign dmem_addr_o   = {data_q.addr[31:2], 2'b00};
  assign dmem_wdata_o  = data_q.wdata;
  assign mem_data_o    = data_q.mdata;
  assign mem_address_o = data_q.addr;
  assign rd_o          = data_q.rd;
  assign RegWrite_o    = data_q.regwrite;
  assign valid_o       = (state_q == StDone) & ~pipeline_flush;
  assign misalign_o    = misalign_q;
  assign bus_err_o     = timeout_hit;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle watchdog.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_i, pipeline_flush, valid_i, ready_o;
  logic [31:0] alu_result_i, store_data_i;
  logic [3:0]  rd_i;
  logic        RegWrite_i, MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] mem_data_o, mem_address_o;
  logic [3:0]  rd_o;
  logic        RegWrite_o, valid_o, ready_i, misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .TimeoutCycles    (4),
    .ClearDataOnReset (1'b1)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .pipeline_flush (pipeline_flush),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .alu_result_i   (alu_result_i),
    .store_data_i   (store_data_i),
    .rd_i           (rd_i),
    .RegWrite_i     (RegWrite_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .funct3_i       (funct3_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .mem_data_o     (mem_data_o),
    .mem_address_o  (mem_address_o),
    .rd_o           (rd_o),
    .RegWrite_o     (RegWrite_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .misalign_o     (misalign_o),
    .bus_err_o      (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [3:0] rd, input logic rw);
    valid_i      = 1'b1;
    MemRead_i    = mr;
    MemWrite_i   = mw;
    funct3_i     = f3;
    alu_result_i = alu;
    store_data_i = sd;
    rd_i         = rd;
    RegWrite_i   = rw;
  endtask

  initial begin
    reset_i = 1'b1; pipeline_flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    alu_result_i = '0; store_data_i = '0; rd_i = '0; RegWrite_i = 1'b0;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_be", dmem_be_o, 0);
    chk("rst_errs", {misalign_o, bus_err_o}, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_rd_rw", {rd_o, RegWrite_o}, 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    #1 chk("idle_ready", ready_o, 1);

    // Pass-through ALU op, one-cycle latency.
    offer(0, 0, 3'b000, 32'h1234, 32'h0, 4'd5, 1);
    tick(); valid_i = 1'b0; #1;
    chk("alu_valid", valid_o, 1);
    chk("alu_data", mem_data_o, 32'h1234);
    chk("alu_rd", rd_o, 5);
    chk("alu_rw", RegWrite_o, 1);
    chk("alu_req", dmem_req_o, 0);
    tick();
    chk("alu_back_idle", valid_o, 0);

    // LB 0x103, grant on the second REQ cycle.
    offer(1, 0, 3'b000, 32'h103, 32'h0, 4'd3, 1);
    tick(); valid_i = 1'b0; #1;
    chk("lb_req", dmem_req_o, 1);
    chk("lb_addr", dmem_addr_o, 32'h100);
    chk("lb_be", dmem_be_o, 4'b1000);
    chk("lb_we", dmem_we_o, 0);
    chk("lb_busy", ready_o, 0);
    tick();
    chk("lb_req_held", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_FFFF; #1;
    chk("lb_wait_noreq", dmem_req_o, 0);
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("lb_valid", valid_o, 1);
    chk("lb_data", mem_data_o, 32'hFFFF_FF80);
    chk("lb_address", mem_address_o, 32'h103);
    chk("lb_rw", RegWrite_o, 1);
    tick();

    // LBU same address, immediate grant.
    offer(1, 0, 3'b100, 32'h103, 32'h0, 4'd3, 1);
    tick(); valid_i = 1'b0; dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_FFFF;
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("lbu_data", mem_data_o, 32'h0000_0080);
    tick();

    // LH 0x102 picks the upper half, sign-extended.
    offer(1, 0, 3'b001, 32'h102, 32'h0, 4'd4, 1);
    tick(); valid_i = 1'b0; #1;
    chk("lh_be", dmem_be_o, 4'b1100);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_7FFF;
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("lh_data", mem_data_o, 32'hFFFF_8001);
    tick();

    // SH 0x202, then a back-to-back ALU op accepted from DONE.
    offer(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 4'd7, 1);
    tick(); valid_i = 1'b0; #1;
    chk("sh_addr", dmem_addr_o, 32'h200);
    chk("sh_be", dmem_be_o, 4'b1100);
    chk("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
    chk("sh_we", dmem_we_o, 1);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("sh_valid", valid_o, 1);
    chk("sh_rw", RegWrite_o, 0);
    chk("sh_data", mem_data_o, 32'h0000_ABCD);
    offer(0, 0, 3'b000, 32'h55, 32'h0, 4'd2, 1);
    #1 chk("b2b_ready", ready_o, 1);
    tick(); valid_i = 1'b0; #1;
    chk("b2b_valid", valid_o, 1);
    chk("b2b_data", mem_data_o, 32'h55);
    chk("b2b_rd", rd_o, 2);
    tick();

    // SB 0x101: byte lane 1, data replicated.
    offer(0, 1, 3'b000, 32'h101, 32'h1234_565A, 4'd1, 1);
    tick(); valid_i = 1'b0; #1;
    chk("sb_be", dmem_be_o, 4'b0010);
    chk("sb_wdata", dmem_wdata_o, 32'h5A5A_5A5A);
    dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0;
    tick();

    // Misaligned LW: no request, error pulse lasts one cycle while DONE is stalled.
    offer(1, 0, 3'b010, 32'h101, 32'h0, 4'd6, 1);
    tick(); valid_i = 1'b0; ready_i = 1'b0; #1;
    chk("mis_pulse", misalign_o, 1);
    chk("mis_noreq", dmem_req_o, 0);
    chk("mis_valid", valid_o, 1);
    chk("mis_rw", RegWrite_o, 0);
    tick();
    chk("mis_pulse_end", misalign_o, 0);
    chk("mis_valid_held", valid_o, 1);
    ready_i = 1'b1;
    tick();

    // Flush while LW waits for data: transaction completes, no result.
    offer(1, 0, 3'b010, 32'h100, 32'h0, 4'd8, 1);
    tick(); valid_i = 1'b0; dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; pipeline_flush = 1'b1;
    tick(); pipeline_flush = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D; #1;
    chk("flush_no_valid_wait", valid_o, 0);
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("flush_no_valid", valid_o, 0);
    chk("flush_idle_ready", ready_o, 1);

    // Flush of a finished ALU result in DONE.
    offer(0, 0, 3'b000, 32'h77, 32'h0, 4'd9, 1);
    tick(); valid_i = 1'b0; pipeline_flush = 1'b1; #1;
    chk("flush_done_masked", valid_o, 0);
    tick(); pipeline_flush = 1'b0; #1;
    chk("flush_done_idle", valid_o, 0);

    // Watchdog: no grant ever; abort in the 4th REQ cycle.
    offer(1, 0, 3'b010, 32'h300, 32'h0, 4'd10, 1);
    tick(); valid_i = 1'b0; #1;
    chk("wd_c1_err", bus_err_o, 0);
    tick(); tick();
    chk("wd_c3_err", bus_err_o, 0);
    tick();
    chk("wd_c4_err", bus_err_o, 1);
    chk("wd_c4_req", dmem_req_o, 1);
    ready_i = 1'b0;
    tick();
    chk("wd_req_drop", dmem_req_o, 0);
    chk("wd_err_end", bus_err_o, 0);
    dmem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wd_stall_valid", valid_o, 1);
      chk("wd_stall_rw", RegWrite_o, 0);
      chk("wd_stall_data", mem_data_o, 32'h300);
      chk("wd_stall_rd", rd_o, 10);
      tick();
    end
    dmem_gnt_i = 1'b0; ready_i = 1'b1;
    tick();
    chk("wd_back_idle", valid_o, 0);

    // Grant in the expiry cycle wins over the timeout.
    offer(0, 1, 3'b010, 32'h400, 32'hDEAD_BEEF, 4'd11, 0);
    tick(); valid_i = 1'b0; #1;
    chk("gw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
    chk("gw_be", dmem_be_o, 4'b1111);
    tick(); tick(); tick(); dmem_gnt_i = 1'b1; #1;
    chk("gw_no_err", bus_err_o, 0);
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("gw_valid", valid_o, 1);
    tick();

    // Reset in the middle of a request withdraws it immediately.
    offer(1, 0, 3'b010, 32'h500, 32'h0, 4'd12, 1);
    tick(); valid_i = 1'b0; #1;
    chk("mid_req", dmem_req_o, 1);
    reset_i = 1'b1; #1;
    chk("mid_rst_req", dmem_req_o, 0);
    chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_data", mem_address_o, 0);
    tick(); reset_i = 1'b0; #1;
    chk("mid_rst_idle", {valid_o, ready_o}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
